// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcodes, one-hot step encodings and the stepper state type.
package cpu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHR = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  typedef logic [6:0] step_t;

  localparam step_t STEP1 = 7'b0000001;
  localparam step_t STEP2 = 7'b0000010;
  localparam step_t STEP3 = 7'b0000100;
  localparam step_t STEP4 = 7'b0001000;
  localparam step_t STEP5 = 7'b0010000;
  localparam step_t STEP6 = 7'b0100000;
  localparam step_t STEP7 = 7'b1000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } stepper_state_t;

  // Fetch-phase control strobes; alu_op travels separately.
  typedef struct packed {
    logic iar_e;
    logic iar_s;
    logic mar_s;
    logic bus1;
    logic acc_s;
    logic acc_e;
    logic ram_e;
    logic ir_s;
    logic exec_en;
  } ctrl_t;

endpackage

// File: rtl/fetch_stepper_if.sv
// Stepper control bundle: the stepper is master, the CPU datapath/decoder is slave.
interface fetch_stepper_if #(parameter int CNT_W = 16);
  import cpu_pkg::*;

  logic             run;
  logic             halt_req;
  step_t            step;
  logic             set_phase;
  logic             iar_e;
  logic             iar_s;
  logic             mar_s;
  logic             bus1;
  logic [2:0]       alu_op;
  logic             acc_s;
  logic             acc_e;
  logic             ram_e;
  logic             ir_s;
  logic             exec_en;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  run, halt_req,
    output step, set_phase, iar_e, iar_s, mar_s, bus1, alu_op, acc_s, acc_e,
           ram_e, ir_s, exec_en, running, halted, instr_cnt
  );

  modport slave (
    output run, halt_req,
    input  step, set_phase, iar_e, iar_s, mar_s, bus1, alu_op, acc_s, acc_e,
           ram_e, ir_s, exec_en, running, halted, instr_cnt
  );

endinterface

// File: rtl/fetch_stepper_step_ring.sv
// 7-position one-hot step ring with an ENABLE/SET phase bit; each step lasts two advances.
module step_ring
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  advance,
  input  logic  clear,
  output step_t step,
  output logic  set_phase
);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      step      <= STEP1;
      set_phase <= 1'b0;
    end else if (advance) begin
      if (set_phase) begin
        step      <= {step[5:0], step[6]};
        set_phase <= 1'b0;
      end else begin
        set_phase <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stepper.sv
// CPU stepper: sequences 7 two-phase steps, decodes fetch strobes for steps 1-3,
// hands steps 4-6 to the decoder and stops at an instruction boundary on request.
module fetch_stepper
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  fetch_stepper_if.master bus
);

  stepper_state_t   state, state_nxt;
  step_t            step;
  logic             set_phase;
  logic             running;
  logic             wrap_edge;
  logic             halt_now;
  logic             halt_pend;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;
  ctrl_t            ctrl;

  assign running   = (state == ST_RUN);
  assign wrap_edge = running && (step == STEP7) && set_phase;
  // A request arriving on the step 7 SET cycle itself still counts.
  assign halt_now  = wrap_edge && (halt_pend || bus.halt_req);

  step_ring u_ring (
    .clk       (clk),
    .reset     (reset),
    .advance   (running),
    .clear     (!running),
    .step      (step),
    .set_phase (set_phase)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.run)  state_nxt = ST_RUN;
      ST_RUN:  if (halt_now) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_pend <= 1'b0;
      halted    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      if (halt_now)          halt_pend <= 1'b0;
      else if (bus.halt_req) halt_pend <= 1'b1;

      if (halt_now)                 halted <= 1'b1;
      else if (!running && bus.run) halted <= 1'b0;

      if (wrap_edge) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // NOTE: defaults first so no branch of the decode leaves a latch behind.
  always_comb begin
    ctrl = '0;
    if (running) begin
      unique case (step)
        STEP1: begin
          ctrl.iar_e = 1'b1;
          ctrl.bus1  = 1'b1;
          ctrl.mar_s = set_phase;
          ctrl.acc_s = set_phase;
        end
        STEP2: begin
          ctrl.ram_e = 1'b1;
          ctrl.ir_s  = set_phase;
        end
        STEP3: begin
          ctrl.acc_e = 1'b1;
          ctrl.iar_s = set_phase;
        end
        STEP4, STEP5, STEP6: ctrl.exec_en = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.step      = step;
  assign bus.set_phase = set_phase;
  assign bus.iar_e     = ctrl.iar_e;
  assign bus.iar_s     = ctrl.iar_s;
  assign bus.mar_s     = ctrl.mar_s;
  assign bus.bus1      = ctrl.bus1;
  assign bus.alu_op    = ALU_ADD;
  assign bus.acc_s     = ctrl.acc_s;
  assign bus.acc_e     = ctrl.acc_e;
  assign bus.ram_e     = ctrl.ram_e;
  assign bus.ir_s      = ctrl.ir_s;
  assign bus.exec_en   = ctrl.exec_en;
  assign bus.running   = running;
  assign bus.halted    = halted;
  assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_fetch_stepper.sv
// Self-checking bench for fetch_stepper: directed scenarios plus random run/halt/reset
// traffic, all compared against a tick-counting reference model.
module tb_fetch_stepper;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_stepper_if #(.CNT_W(16)) bus ();
  fetch_stepper_if #(.CNT_W(4))  bus_w ();

  fetch_stepper #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Narrow-counter copy used to observe counter wrap in a short run.
  fetch_stepper #(.CNT_W(4)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w.master)
  );

  assign bus_w.run      = bus.run;
  assign bus_w.halt_req = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the 14-cycle instruction plus status bits.
  bit          m_running;
  bit          m_halted;
  bit          m_pend;
  int          m_tick;
  int unsigned m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {iar_e, iar_s, mar_s, bus1, acc_s, acc_e, ram_e, ir_s, exec_en}
  function automatic logic [8:0] exp_strobes();
    int  s;
    bit  set;
    logic [8:0] v;
    v   = '0;
    s   = m_tick / 2 + 1;
    set = (m_tick % 2) == 1;
    if (m_running) begin
      case (s)
        1: begin v[8] = 1'b1; v[5] = 1'b1; v[6] = set; v[4] = set; end
        2: begin v[2] = 1'b1; v[1] = set; end
        3: begin v[3] = 1'b1; v[7] = set; end
        4, 5, 6: v[0] = 1'b1;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic model_edge(input bit r, input bit h, input bit rst);
    bit pend_nxt;
    if (rst) begin
      m_running = 0; m_halted = 0; m_pend = 0; m_tick = 0; m_cnt = 0;
      return;
    end
    pend_nxt = m_pend | h;
    if (m_running) begin
      if (m_tick == 13) begin
        m_tick = 0;
        m_cnt  = (m_cnt + 1) % 65536;
        if (pend_nxt) begin
          m_running = 0; m_halted = 1; m_pend = 0;
        end else begin
          m_pend = pend_nxt;
        end
      end else begin
        m_tick++;
        m_pend = pend_nxt;
      end
    end else begin
      m_pend = pend_nxt;
      if (r) begin
        m_running = 1; m_halted = 0; m_tick = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [8:0] obs;
    obs = {bus.iar_e, bus.iar_s, bus.mar_s, bus.bus1, bus.acc_s,
           bus.acc_e, bus.ram_e, bus.ir_s, bus.exec_en};
    check({tag, ".step"},      32'(bus.step),      32'(7'b1 << (m_tick / 2)));
    check({tag, ".set_phase"}, 32'(bus.set_phase), 32'(m_tick % 2));
    check({tag, ".running"},   32'(bus.running),   32'(m_running));
    check({tag, ".halted"},    32'(bus.halted),    32'(m_halted));
    check({tag, ".instr_cnt"}, 32'(bus.instr_cnt), m_cnt);
    check({tag, ".strobes"},   32'(obs),           32'(exp_strobes()));
    check({tag, ".alu_op"},    32'(bus.alu_op),    32'(ALU_ADD));
  endtask

  task automatic cycle(input string tag, input bit r, input bit h, input bit rst);
    @(negedge clk);
    bus.run      = r;
    bus.halt_req = h;
    reset        = rst;
    @(posedge clk);
    model_edge(r, h, rst);
    #1;
    check_all(tag);
  endtask

  initial begin
    int n;
    bus.run      = 1'b0;
    bus.halt_req = 1'b0;
    m_running = 0; m_halted = 0; m_pend = 0; m_tick = 0; m_cnt = 0;

    // 1: reset state, then first fetch steps
    cycle("reset", 0, 0, 1);
    cycle("idle", 0, 0, 0);
    check("idle_strobes", 32'({bus.iar_e, bus.mar_s, bus.ram_e, bus.exec_en}), 32'd0);
    cycle("t1_c1", 1, 0, 0);
    check("t1_c1_iar_e", 32'(bus.iar_e), 32'd1);
    check("t1_c1_mar_s", 32'(bus.mar_s), 32'd0);
    cycle("t1_c2", 0, 0, 0);
    check("t1_c2_mar_acc", 32'({bus.mar_s, bus.acc_s, bus.bus1}), 32'h7);
    cycle("t1_c3", 0, 0, 0);
    cycle("t1_c4", 0, 0, 0);
    check("t1_c4_ir_s", 32'(bus.ir_s), 32'd1);
    cycle("t1_c5", 0, 0, 0);
    cycle("t1_c6", 0, 0, 0);
    check("t1_c6_iar_s", 32'(bus.iar_s), 32'd1);

    // 2: three free-running instructions; stray run pulses must be ignored
    cycle("t2_rst", 0, 0, 1);
    cycle("t2_run", 1, 0, 0);
    n = int'(bus.exec_en);
    for (int i = 0; i < 41; i++) begin
      cycle("t2", ($urandom_range(0, 3) == 0), 0, 0);
      n += int'(bus.exec_en);
    end
    check("t2_exec_cycles", n, 18);
    cycle("t2_wrap", 0, 0, 0);
    check("t2_instr_cnt", 32'(bus.instr_cnt), 32'd3);
    check("t2_step", 32'(bus.step), 32'(STEP1));

    // 3: halt request during step 2
    cycle("t3_rst", 0, 0, 1);
    cycle("t3_run", 1, 0, 0);
    cycle("t3", 0, 0, 0);
    cycle("t3", 0, 0, 0);
    cycle("t3_halt", 0, 1, 0);
    for (int i = 0; i < 40 && bus.running; i++) cycle("t3_wait", 0, 0, 0);
    check("t3_running", 32'(bus.running), 32'd0);
    check("t3_halted", 32'(bus.halted), 32'd1);
    check("t3_step", 32'(bus.step), 32'(STEP1));
    check("t3_instr_cnt", 32'(bus.instr_cnt), 32'd1);
    cycle("t3_after", 0, 0, 0);

    // 4: run and halt_req together from idle
    cycle("t4_rst", 0, 0, 1);
    cycle("t4_start", 1, 1, 0);
    n = int'(bus.running);
    for (int i = 0; i < 40; i++) begin
      cycle("t4", 0, 0, 0);
      n += int'(bus.running);
    end
    check("t4_run_cycles", n, 14);
    check("t4_instr_cnt", 32'(bus.instr_cnt), 32'd1);
    check("t4_halted", 32'(bus.halted), 32'd1);

    // 5: reset in step 5 SET
    cycle("t5_run", 1, 0, 0);
    for (int i = 0; i < 9; i++) cycle("t5", 0, 0, 0);
    check("t5_in_step5_set", 32'({bus.step, bus.set_phase}), 32'({STEP5, 1'b1}));
    cycle("t5_rst", 0, 0, 1);
    check("t5_step", 32'(bus.step), 32'(STEP1));
    check("t5_running", 32'(bus.running), 32'd0);
    check("t5_instr_cnt", 32'(bus.instr_cnt), 32'd0);

    // random run / halt / occasional reset traffic
    for (int i = 0; i < 600; i++)
      cycle("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 249) == 0));

    // 6: counter wrap on the 4-bit copy (16 instructions)
    cycle("t6_rst", 0, 0, 1);
    cycle("t6_run", 1, 0, 0);
    for (int i = 0; i < 15 * 14; i++) cycle("t6", 0, 0, 0);
    check("t6_cnt_15", 32'(bus_w.instr_cnt), 32'd15);
    for (int i = 0; i < 14; i++) cycle("t6", 0, 0, 0);
    check("t6_cnt_wrap", 32'(bus_w.instr_cnt), 32'd0);
    check("t6_running", 32'(bus_w.running), 32'd1);
    check("t6_step", 32'(bus_w.step), 32'(STEP1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
